// File: rtl/round_ctrl_if.sv
// round_ctrl_if: frame/touch/hit inputs and round status outputs of the round controller
interface round_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       touch_lady;
  logic       kong_hit;
  logic       game_en;
  logic [1:0] lives;
  logic       donkey_win;
  logic       kong_win;
  logic       round_end;
  modport master (
    output frame_tick, start, touch_lady, kong_hit,
    input  game_en, lives, donkey_win, kong_win, round_end
  );
  modport slave (
    input  frame_tick, start, touch_lady, kong_hit,
    output game_en, lives, donkey_win, kong_win, round_end
  );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: round FSM tracking Donkey lives, win confirmation and result hold
module round_ctrl #(
  parameter int LIVES         = 3,
  parameter int HOLD_FRAMES   = 4,
  parameter int INVULN_FRAMES = 60,
  parameter int RESULT_FRAMES = 180
) (
  input logic clk,
  input logic rst,
  round_ctrl_if.slave i_bus
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int RW = $clog2(RESULT_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_FRAMES);
  localparam logic [IW-1:0] INVULN_INIT = IW'(INVULN_FRAMES);
  localparam logic [RW-1:0] RESULT_LAST = RW'(RESULT_FRAMES - 1);
  localparam logic [RW-1:0] RESULT_MAX  = RW'(RESULT_FRAMES);
  localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);
  typedef enum logic [1:0] {IDLE, PLAY, RESULT} state_t;
  state_t r_state, w_state;
  logic [HW-1:0] r_hold_cnt, w_hold_cnt;
  logic [IW-1:0] r_invuln_cnt, w_invuln_cnt;
  logic [RW-1:0] r_result_cnt, w_result_cnt;
  logic [1:0] r_lives, w_lives;
  logic r_donkey_win, w_donkey_win;
  logic r_kong_win, w_kong_win;
  logic r_round_end, w_round_end;
  logic r_game_en, w_game_en;
  logic w_start, w_win, w_hit, w_kong;
  // A confirmed Donkey win pre-empts a hit arriving on the same cycle
  assign w_start = r_state == IDLE && i_bus.start;
  assign w_win   = r_state == PLAY && i_bus.touch_lady && i_bus.frame_tick && r_hold_cnt == HOLD_LAST;
  assign w_hit   = r_state == PLAY && i_bus.kong_hit && r_invuln_cnt == '0 && !w_win;
  assign w_kong  = w_hit && r_lives == 2'd1;
  // State and all registered outputs/counters; reset aborts any round without a result
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_invuln_cnt <= '0;
      r_result_cnt <= '0;
      r_lives      <= LIVES_INIT;
      r_donkey_win <= 1'b0;
      r_kong_win   <= 1'b0;
      r_round_end  <= 1'b0;
      r_game_en    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold_cnt   <= w_hold_cnt;
      r_invuln_cnt <= w_invuln_cnt;
      r_result_cnt <= w_result_cnt;
      r_lives      <= w_lives;
      r_donkey_win <= w_donkey_win;
      r_kong_win   <= w_kong_win;
      r_round_end  <= w_round_end;
      r_game_en    <= w_game_en;
    end
  end
  // Next state: start opens a round, either win closes it, result timeout returns to idle
  always_comb begin
    w_state = r_state;
    if (w_start) w_state = PLAY;
    if (w_win || w_kong) w_state = RESULT;
    if (r_state == RESULT && i_bus.frame_tick && r_result_cnt == RESULT_LAST) w_state = IDLE;
  end
  // Next values of counters and outputs; counters saturate or clear, never wrap
  always_comb begin
    w_hold_cnt   = (r_state != PLAY || !i_bus.touch_lady) ? '0 :
                   (i_bus.frame_tick && r_hold_cnt != HOLD_MAX) ? r_hold_cnt + HW'(1) : r_hold_cnt;
    w_invuln_cnt = (r_state == IDLE) ? '0 : w_hit ? INVULN_INIT :
                   (r_state == PLAY && i_bus.frame_tick && r_invuln_cnt != '0) ? r_invuln_cnt - IW'(1) : r_invuln_cnt;
    w_result_cnt = (r_state != RESULT) ? '0 :
                   (i_bus.frame_tick && r_result_cnt != RESULT_MAX) ? r_result_cnt + RW'(1) : r_result_cnt;
    w_lives      = w_start ? LIVES_INIT : w_hit ? r_lives - 2'd1 : r_lives;
    w_donkey_win = w_start ? 1'b0 : r_donkey_win | w_win;
    w_kong_win   = w_start ? 1'b0 : r_kong_win | w_kong;
    w_round_end  = w_win | w_kong;
    w_game_en    = w_state == PLAY;
  end
  assign i_bus.game_en    = r_game_en;
  assign i_bus.lives      = r_lives;
  assign i_bus.donkey_win = r_donkey_win;
  assign i_bus.kong_win   = r_kong_win;
  assign i_bus.round_end  = r_round_end;
endmodule
